// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one APB master/SRAM
// interface, holding each transfer for a fixed SETUP + ACCESS window.
module apb_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int XFER_CYCLES = 2,
  parameter int AW          = 8,
  parameter int DW          = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic                  start_transfer,
  output logic                  rw_mode,
  output logic [DW-1:0]         master_wdata,
  output logic [AW-1:0]         master_waddr,
  output logic [AW-1:0]         master_raddr,
  output logic                  slave_write_enable,
  input  logic [DW-1:0]         slave_rdata,
  output logic [1:0]            dbg_state
);

  localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_last_grant;
  logic [2:0]      r_grant;
  logic            r_rw;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [CW-1:0]   r_cnt;

  logic [7:0]      w_req8;
  logic [3:0]      w_idx;
  logic            w_found;
  logic [2:0]      w_winner;
  logic            w_access_last;

  // Rotating priority: scan starts one past the last winner and wraps.
  always_comb begin
    w_req8   = 8'(req);
    w_idx    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = {1'b0, r_last_grant} + 4'(i);
      if (w_idx >= 4'(NUM_REQ)) w_idx = w_idx - 4'(NUM_REQ);
      if (!w_found && w_req8[w_idx[2:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[2:0];
      end
    end
  end

  assign w_access_last = (r_state == S_ACCESS) && (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_access_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 3'(NUM_REQ - 1);
      r_grant      <= '0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_winner;
        r_rw    <= req_rw[int'(w_winner)];
        r_addr  <= req_addr[int'(w_winner)*AW +: AW];
        r_wdata <= req_wdata[int'(w_winner)*DW +: DW];
      end
      if (r_state == S_SETUP) begin
        r_cnt <= CW'(XFER_CYCLES - 1);
      end else if (r_state == S_ACCESS && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Read data is captured on the edge entering DONE so it is valid alongside ack.
      if (w_access_last && !r_rw) r_rdata <= slave_rdata;
      if (r_state == S_DONE) r_last_grant <= r_grant;
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (r_state == S_DONE) && (r_grant == 3'(i));
    end
  end

  assign busy               = (r_state != S_IDLE);
  assign start_transfer     = (r_state == S_SETUP);
  assign slave_write_enable = r_rw && ((r_state == S_SETUP) || (r_state == S_ACCESS));
  assign rw_mode            = r_rw;
  assign master_waddr       = r_addr;
  assign master_raddr       = r_addr;
  assign master_wdata       = r_wdata;
  assign grant_id           = r_grant;
  assign rdata              = r_rdata;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Directed bench for apb_request_arbiter with a simple SRAM standing in for the
// APB interface; expected grants, latencies and data are hand-derived.
module tb_apb_request_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic [3:0]  req, req_rw;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [2:0]  grant_id;
  logic        start_transfer, rw_mode, slave_write_enable;
  logic [7:0]  master_wdata, master_waddr, master_raddr, slave_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  logic [7:0] mem [256];

  apb_request_arbiter #(.NUM_REQ(4), .XFER_CYCLES(2), .AW(8), .DW(8)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .start_transfer(start_transfer), .rw_mode(rw_mode),
    .master_wdata(master_wdata), .master_waddr(master_waddr), .master_raddr(master_raddr),
    .slave_write_enable(slave_write_enable), .slave_rdata(slave_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // SRAM model behind the interface
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge sys_clk) if (slave_write_enable) mem[master_waddr] <= master_wdata;
  assign slave_rdata = mem[master_raddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_reset) begin
      check("inv_ack_onehot0", 32'($onehot0(ack)), 1);
      check("inv_swe_idle", 32'(slave_write_enable && (dbg_state == 2'd0)), 0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, start_transfer, 0);
    check({tag, "_swe"}, slave_write_enable, 0);
    check({tag, "_rw"}, rw_mode, 0);
    check({tag, "_waddr"}, master_waddr, 0);
    check({tag, "_raddr"}, master_raddr, 0);
    check({tag, "_wdata"}, master_wdata, 0);
    check({tag, "_gid"}, grant_id, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic pulse_reset();
    sys_reset = 1'b0;
    @(negedge sys_clk);
    sys_reset = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic set_req(input int id, input logic rw, input logic [7:0] addr, input logic [7:0] wd);
    req_rw[id]          = rw;
    req_addr[id*8 +: 8] = addr;
    req_wdata[id*8 +: 8] = wd;
    req[id]             = 1'b1;
  endtask

  // Single transfer from an idle arbiter; checks every cycle through the return to IDLE.
  task automatic do_xfer(input string tag, input int id, input logic rw,
                         input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] exp_rd);
    set_req(id, rw, addr, wd);
    @(negedge sys_clk);
    check({tag, "_setup_start"}, start_transfer, 1);
    check({tag, "_setup_busy"}, busy, 1);
    check({tag, "_setup_gid"}, grant_id, id);
    check({tag, "_setup_rw"}, rw_mode, rw);
    check({tag, "_setup_swe"}, slave_write_enable, rw);
    check({tag, "_setup_waddr"}, master_waddr, addr);
    check({tag, "_setup_raddr"}, master_raddr, addr);
    check({tag, "_setup_wdata"}, master_wdata, wd);
    check({tag, "_setup_ack"}, ack, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge sys_clk);
      check({tag, "_acc_start"}, start_transfer, 0);
      check({tag, "_acc_swe"}, slave_write_enable, rw);
      check({tag, "_acc_busy"}, busy, 1);
      check({tag, "_acc_ack"}, ack, 0);
      check({tag, "_acc_raddr"}, master_raddr, addr);
    end
    @(negedge sys_clk);
    check({tag, "_done_ack"}, ack, 32'(1) << id);
    check({tag, "_done_swe"}, slave_write_enable, 0);
    check({tag, "_done_busy"}, busy, 1);
    check({tag, "_done_rdata"}, rdata, exp_rd);
    req[id] = 1'b0;
    @(negedge sys_clk);
    check({tag, "_idle_ack"}, ack, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_start"}, start_transfer, 0);
    check({tag, "_idle_waddr"}, master_waddr, addr);
    check({tag, "_idle_rw"}, rw_mode, rw);
  endtask

  // Waits (bounded) for the next ack; checks who got it and how many negedges it took.
  task automatic wait_ack(input string tag, input int exp_id, input int exp_wait);
    int waited;
    int idx;
    waited = 0;
    idx = -1;
    while (waited < 30 && idx < 0) begin
      @(negedge sys_clk);
      waited++;
      for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
    end
    check({tag, "_id"}, idx, exp_id);
    check({tag, "_lat"}, waited, exp_wait);
  endtask

  initial begin
    sys_reset = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("rst");
    sys_reset = 1'b1;
    @(negedge sys_clk);

    // single write then read-back of the same address
    do_xfer("s1_wr", 0, 1'b1, 8'h10, 8'hA5, 8'h00);
    do_xfer("s2_rd", 2, 1'b0, 8'h10, 8'h00, 8'hA5);

    // contention from a fresh reset: all four write address i, data 0x50+i
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(i), 8'(8'h50 + i));
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    for (int k = 0; k < 5; k++) begin
      wait_ack("s3_rr", int'(exp_q.pop_front()), (k == 0) ? 4 : 5);
      if (k == 4) req = '0;
    end
    @(negedge sys_clk);
    check("s3_idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) do_xfer("s3_rb", i, 1'b0, 8'(i), 8'h00, 8'(8'h50 + i));

    // fairness: requester 1 holds req while 3 arrives mid-transfer
    set_req(1, 1'b1, 8'h31, 8'h61);
    repeat (2) @(negedge sys_clk);
    set_req(3, 1'b1, 8'h33, 8'h63);
    wait_ack("s4_first", 1, 2);
    wait_ack("s4_second", 3, 5);
    req[3] = 1'b0;
    wait_ack("s4_third", 1, 5);
    req[1] = 1'b0;
    @(negedge sys_clk);

    // request withdrawn during ACCESS still completes with ack
    set_req(2, 1'b0, 8'h02, 8'h00);
    @(negedge sys_clk);
    check("s5_start", start_transfer, 1);
    check("s5_gid", grant_id, 2);
    @(negedge sys_clk);
    check("s5_acc_busy", busy, 1);
    req[2] = 1'b0;
    wait_ack("s5_ack", 2, 2);
    check("s5_rdata", rdata, 8'h52);
    @(negedge sys_clk);
    check("s5_idle_busy", busy, 0);
    check("s5_idle_state", dbg_state, 0);

    // reset during the ACCESS window of a write
    set_req(2, 1'b1, 8'h20, 8'h77);
    repeat (2) @(negedge sys_clk);
    check("s6_acc_swe", slave_write_enable, 1);
    check("s6_acc_busy", busy, 1);
    #1 sys_reset = 1'b0;
    #1 check_all_zero("s6_abort");
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      check("s6_rst_ack", ack, 0);
    end
    req = '0;
    sys_reset = 1'b1;
    @(negedge sys_clk);
    set_req(0, 1'b1, 8'h40, 8'h11);
    set_req(2, 1'b1, 8'h42, 8'h22);
    wait_ack("s6_prio0", 0, 4);
    req[0] = 1'b0;
    wait_ack("s6_then2", 2, 5);
    req[2] = 1'b0;
    @(negedge sys_clk);
    do_xfer("s6_rb", 1, 1'b0, 8'h40, 8'h00, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_request_arbiter.md
Name: apb_request_arbiter

Overview:
- Round-robin arbiter and transfer sequencer that shares one apb_interface (APB master + SRAM slave) between NUM_REQ independent requesters.
- Serialises requests and latches each request's command, address and data.
- Drives the interface's start_transfer / rw_mode / address / data / write-enable inputs for a fixed transfer window.
- Returns read data and a one-cycle ack to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- XFER_CYCLES, 2, cycles the ACCESS window is held after the setup cycle (min 1).
- AW, 8, address width.
- DW, 8, data width.

Ports:
- sys_clk  input  1  system clock, rising-edge.
- sys_reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester transfer request; held until ack.
- req_rw  input  NUM_REQ  per-requester direction; 1 = write, 0 = read.
- req_addr  input  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  input  NUM_REQ*DW  packed write data; requester i at [i*DW +: DW].
- ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  output  DW  read data of the most recent completed read.
- busy  output  1  high in SETUP, ACCESS and DONE.
- grant_id  output  3  index of the current or last granted requester.
- start_transfer  output  1  to apb_interface.
- rw_mode  output  1  to apb_interface; 1 = write.
- master_wdata  output  DW  to apb_interface.
- master_waddr  output  AW  to apb_interface.
- master_raddr  output  AW  to apb_interface.
- slave_write_enable  output  1  to apb_interface.
- slave_rdata  input  DW  from apb_interface.

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE.
  - All outputs = 0: ack, rdata, busy, grant_id, start_transfer, rw_mode, master_wdata, master_waddr, master_raddr, slave_write_enable.
  - Internal last_grant = NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If req != 0, scan from last_grant+1 upward, wrapping modulo NUM_REQ; the first set bit wins.
  - Latch winner's req_rw, req_addr and req_wdata into internal registers; set grant_id; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (exactly one cycle):
  - start_transfer = 1, busy = 1.
  - rw_mode = latched rw; slave_write_enable = latched rw.
  - master_waddr = master_raddr = latched addr; master_wdata = latched wdata.
  - Load counter with XFER_CYCLES-1; go to ACCESS.
- ACCESS:
  - start_transfer = 0; all other interface outputs hold their SETUP values.
  - Decrement counter; when counter == 0, go to DONE. ACCESS therefore lasts exactly XFER_CYCLES cycles.
- DONE (exactly one cycle):
  - ack[grant_id] = 1.
  - If read, rdata <= slave_rdata sampled on this edge; if write, rdata holds its previous value.
  - slave_write_enable = 0; last_grant <= grant_id; go to IDLE.
- Leaving DONE: master_* and rw_mode hold their last values; start_transfer and slave_write_enable = 0.
- Latency:
  - req sampled high in IDLE at cycle 0 → start_transfer at cycle 1 → ack at cycle XFER_CYCLES+2.
  - Sustained throughput is one transfer per XFER_CYCLES+3 cycles.
- Request changes mid-transfer:
  - Changes to req, req_rw, req_addr or req_wdata after the grant are ignored.
  - If the granted req drops mid-transfer, the transfer still completes and ack still pulses.
- Back-to-back requests from one requester:
  - A requester still holding req in the IDLE cycle after its ack is re-arbitrated normally.
  - Round-robin guarantees every other pending requester is served before it repeats.
- Simultaneous requests: at most one grant per IDLE cycle; no ack ever reaches a non-granted requester.
- Reset mid-operation: the transfer is aborted immediately, no ack is issued, and all outputs return to reset values.
- Invariants:
  - ack is onehot0.
  - start_transfer is high exactly once per grant.
  - slave_write_enable is never high in IDLE.

Test Plan:
1. Single write: req[0]=1, rw=1, addr=0x10, wdata=0xA5, XFER_CYCLES=2 → start_transfer at cycle 1; slave_write_enable high cycles 1-3; ack[0] at cycle 4; a later read of 0x10 returns rdata=0xA5.
2. Single read: req[2]=1, rw=0, addr=0x10 after scenario 1 → master_raddr=0x10; ack[2] at cycle 4 with rdata=0xA5; slave_write_enable stays 0 throughout.
3. Contention: req=4'b1111 held, each requester writes addr=i, data=0x50+i → grant order 0,1,2,3,0; acks 5 cycles apart; readback of addresses 0-3 gives 0x50-0x53.
4. Fairness: req[1] held continuously while req[3] asserts during requester 1's transfer → next grant goes to 3, then 1; requester 1 is never granted twice in a row while req[3] is pending.
5. Request withdrawn: req[2] drops during ACCESS → transfer completes, ack[2] still pulses, arbiter returns to IDLE.
6. Reset mid-transfer: sys_reset low during ACCESS of a write → all outputs 0 immediately, no ack; after release, requester 0 has top priority again.
